// File: rtl/mult_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : mult_arb_pkg
// | Brief    : Shared sizes and packed-operand slicing for the 4-way multiplier arbiter.
// | Revision : 1.0  initial release
// +-----------------------------------------------------------------------------
package mult_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int OP_W   = 8;
  localparam int PROD_W = 2 * OP_W;
  localparam int ID_W   = 2;
  localparam int BUS_W  = N_REQ * OP_W;

  // Requester i owns bits [OP_W*i +: OP_W] of a packed operand bus.
  function automatic logic [OP_W-1:0] op_slice(input logic [BUS_W-1:0] bus,
                                               input logic [ID_W-1:0]  id);
    return bus[int'(id)*OP_W +: OP_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb4.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : rr_arb4
// | Brief    : Combinational 4-way round-robin arbiter, search starts after 'last'.
// | Revision : 1.0  initial release
// +-----------------------------------------------------------------------------
module rr_arb4
  import mult_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    grant   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = last + ID_W'(k);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_arb4.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : mult_arb4
// | Brief    : Four requesters share one external multiplier through an op/rsp pipeline.
// | Revision : 1.0  initial release
// +-----------------------------------------------------------------------------
module mult_arb4 #(
  parameter int N_REQ = mult_arb_pkg::N_REQ,
  parameter int OP_W  = mult_arb_pkg::OP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_x,
  input  logic [N_REQ*OP_W-1:0] req_y,
  output logic [OP_W-1:0]       mul_x,
  output logic [OP_W-1:0]       mul_y,
  input  logic [2*OP_W-1:0]     mul_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_id,
  output logic [2*OP_W-1:0]     rsp_z
);

  import mult_arb_pkg::*;

  logic              r_op_valid;
  logic [ID_W-1:0]   r_op_id;
  logic [OP_W-1:0]   r_op_x;
  logic [OP_W-1:0]   r_op_y;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [2*OP_W-1:0] r_rsp_z;
  logic [ID_W-1:0]   r_last;

  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_rsp_load;
  logic              w_op_load;
  logic              w_accept;

  rr_arb4 u_arb (
    .req   (req_valid),
    .last  (r_last),
    .grant (w_grant)
  );

  // A stalled rsp stage only blocks the op stage when the op stage is occupied.
  assign w_rsp_load = ~r_rsp_valid | rsp_ready;
  assign w_op_load  = ~r_op_valid | w_rsp_load;
  assign req_ready  = (rst_n && w_op_load) ? w_grant : '0;
  assign w_accept   = |req_ready;

  always_comb begin
    w_gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) w_gnt_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid <= 1'b0;
      r_op_id    <= '0;
      r_op_x     <= '0;
      r_op_y     <= '0;
      r_last     <= ID_W'(N_REQ - 1);
    end else if (w_op_load) begin
      r_op_valid <= w_accept;
      if (w_accept) begin
        r_op_id <= w_gnt_id;
        r_op_x  <= op_slice(req_x, w_gnt_id);
        r_op_y  <= op_slice(req_y, w_gnt_id);
        r_last  <= w_gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_z     <= '0;
    end else if (w_rsp_load) begin
      r_rsp_valid <= r_op_valid;
      r_rsp_id    <= r_op_id;
      r_rsp_z     <= mul_z;
    end
  end

  assign mul_x     = r_op_x;
  assign mul_y     = r_op_y;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_z     = r_rsp_z;

endmodule
`default_nettype wire

// File: tb/tb_mult_arb4.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module   : tb_mult_arb4
// | Brief    : Scoreboard bench for mult_arb4 with an exact-product multiplier stub.
// | Revision : 1.0  initial release
// +-----------------------------------------------------------------------------
module tb_mult_arb4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic [15:0] mul_z;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_z;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] z;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   tb_last = 3;

  always #5 clk = ~clk;

  assign mul_z = 16'(mul_x) * 16'(mul_y);

  mult_arb4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_z     (mul_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z)
  );

  // Handshakes are sampled mid-cycle; inputs change 1 time unit after posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      n_total++;
      if (!$onehot0(req_ready) || ((req_ready & ~req_valid) != 4'b0000)) begin
        $display("FAIL ready_legal: req_ready=%b req_valid=%b", req_ready, req_valid);
      end else begin
        n_pass++;
      end
      if (rsp_valid && rsp_ready) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL rsp_spurious: got id=%0d z=%h, expected no response", rsp_id, rsp_z);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rsp_id !== e.id || rsp_z !== e.z)
            $display("FAIL rsp_data: got id=%0d z=%h, expected id=%0d z=%h", rsp_id, rsp_z, e.id, e.z);
          else
            n_pass++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.id = 2'(i);
          e.z  = 16'(req_x[i*8 +: 8]) * 16'(req_y[i*8 +: 8]);
          q.push_back(e);
          tb_last = i;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int left = 40;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    #2;
    while ((q.size() != 0 || rsp_valid) && left > 0) begin
      tick();
      #2;
      left--;
    end
    n_total++;
    if (q.size() != 0 || rsp_valid)
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
    else
      n_pass++;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_x     = 32'hFFFF_FFFF;
    req_y     = 32'hFFFF_FFFF;
    rsp_ready = 1'b1;
    #3;
    n_total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      $display("FAIL reset_ctrl: rsp_valid=%b req_ready=%b, expected 0 and 0000", rsp_valid, req_ready);
    end else begin
      n_pass++;
    end
    n_total++;
    if (mul_x !== 8'h00 || mul_y !== 8'h00 || rsp_z !== 16'h0000 || rsp_id !== 2'd0) begin
      $display("FAIL reset_data: mul_x=%h mul_y=%h rsp_z=%h rsp_id=%0d, expected all 0", mul_x, mul_y, rsp_z, rsp_id);
    end else begin
      n_pass++;
    end
    tick();
    tick();
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    tb_last   = 3;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = 4'b1111;
      req_x     = $urandom;
      req_y     = $urandom;
      #2;
      exp_rdy = 4'b0001 << ((tb_last + 1) % 4);
      n_total++;
      if (req_ready !== exp_rdy)
        $display("FAIL rr_order: cycle %0d req_ready=%b, expected %b", c, req_ready, exp_rdy);
      else
        n_pass++;
      if (c >= 2) begin
        n_total++;
        if (rsp_valid !== 1'b1)
          $display("FAIL rr_rate: cycle %0d rsp_valid=%b, expected 1", c, rsp_valid);
        else
          n_pass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_x     = 32'h0000_00FF;
    req_y     = 32'h0000_00FF;
    #2;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: req_ready=%b, expected 0001", req_ready);
    else n_pass++;
    tick();
    req_valid = 4'b0000;
    #2;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL single_early: rsp_valid=%b at T+1, expected 0", rsp_valid);
    else n_pass++;
    tick();
    #2;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== 16'hFE01)
      $display("FAIL single_rsp: valid=%b id=%0d z=%h, expected 1 0 fe01", rsp_valid, rsp_id, rsp_z);
    else
      n_pass++;
    tick();
    drain();
  endtask

  task automatic test_priority();
    rsp_ready = 1'b1;
    req_x     = 32'h0403_0201;
    req_y     = 32'h0807_0605;
    req_valid = 4'b0100;
    #2;
    n_total++;
    if (req_ready !== 4'b0100) $display("FAIL prio_first: req_ready=%b, expected 0100", req_ready);
    else n_pass++;
    tick();
    req_valid = 4'b0101;
    #2;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL prio_wrap: req_ready=%b, expected 0001", req_ready);
    else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_rdy;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 4'b1111;
      req_x     = $urandom;
      req_y     = $urandom;
      #2;
      n_total++;
      if (c < 2) begin
        exp_rdy = 4'b0001 << ((tb_last + 1) % 4);
        if (req_ready !== exp_rdy)
          $display("FAIL bp_fill: cycle %0d req_ready=%b, expected %b", c, req_ready, exp_rdy);
        else
          n_pass++;
      end else begin
        if (req_ready !== 4'b0000 || q.size() != 2)
          $display("FAIL bp_full: cycle %0d req_ready=%b inflight=%0d, expected 0000 and 2", c, req_ready, q.size());
        else
          n_pass++;
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_id !== q[0].id || rsp_z !== q[0].z)
          $display("FAIL bp_hold: cycle %0d valid=%b id=%0d z=%h, expected 1 %0d %h", c, rsp_valid, rsp_id, rsp_z, q[0].id, q[0].z);
        else
          n_pass++;
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    req_x     = 32'h1122_3344;
    req_y     = 32'h5566_7788;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000)
      $display("FAIL rst_mid: rsp_valid=%b req_ready=%b, expected 0 and 0000", rsp_valid, req_ready);
    else
      n_pass++;
    q.delete();
    tb_last = 3;
    tick();
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #2;
    n_total++;
    if (req_ready !== 4'b0001 || rsp_valid !== 1'b0)
      $display("FAIL rst_grant: req_ready=%b rsp_valid=%b, expected 0001 and 0", req_ready, rsp_valid);
    else
      n_pass++;
    tick();
    #2;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL rst_stale: rsp_valid=%b, expected 0", rsp_valid);
    else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      req_valid = 4'($urandom);
      req_x     = $urandom;
      req_y     = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_priority();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
